tile_local_arbiter: RTL



---
 rtl/tile_local_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tile_local_arbiter.sv
// Merges NUM_CH AXI-Stream sources onto the tile switch local ingress port.
// Packets are never interleaved, grants rotate round-robin, and the output is registered.
module tile_local_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int BW          = 32,
    parameter int XY_SZ       = 3,
    parameter int STAMP_SRC   = 1,
    parameter int HDR_SRC_LSB = 0,
    localparam int BWB        = BW / 8,
    localparam int GW         = $clog2(NUM_CH)
) (
    input  logic                  clk_line,
    input  logic                  clk_line_rst_low,
    input  logic [2*XY_SZ-1:0]    HsrcId,
    input  logic [NUM_CH-1:0]     in_TVALID,
    input  logic [NUM_CH*BW-1:0]  in_TDATA,
    input  logic [NUM_CH*BWB-1:0] in_TKEEP,
    input  logic [NUM_CH-1:0]     in_TLAST,
    output logic [NUM_CH-1:0]     in_TREADY,
    output logic                  out_TVALID,
    output logic [BW-1:0]         out_TDATA,
    output logic [BWB-1:0]        out_TKEEP,
    output logic                  out_TLAST,
    input  logic                  out_TREADY,
    output logic [GW-1:0]         grant_id,
    output logic [31:0]           stat_pkts
);
    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_LOCK  = 1'b1;
    localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);

    logic [0:0]     state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  rr_q, rr_d;
    logic           first_q, first_d;
    logic           out_valid_q, out_valid_d;
    logic [BW-1:0]  out_data_q;
    logic [BWB-1:0] out_keep_q;
    logic           out_last_q;
    logic [31:0]    stat_q;

    logic           out_space;
    logic           accept;
    logic           sel_valid;
    logic           sel_last;
    logic [BW-1:0]  sel_data;
    logic [BW-1:0]  hdr_data;
    logic [BWB-1:0] sel_keep;
    logic [GW-1:0]  pick;

    // The output register can take a beat when empty or draining this cycle.
    assign out_space = !out_valid_q || out_TREADY;
    assign sel_valid = in_TVALID[grant_q];
    assign sel_last  = in_TLAST[grant_q];
    assign sel_data  = in_TDATA[int'(grant_q) * BW +: BW];
    assign sel_keep  = in_TKEEP[int'(grant_q) * BWB +: BWB];
    assign accept    = (state_q == S_LOCK) && sel_valid && out_space;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign in_TREADY[gi] = (state_q == S_LOCK) && (grant_q == GW'(gi)) && out_space;
        end
    endgenerate

    // Scan downwards so the valid channel closest to rr_q is the last (winning) assignment.
    always_comb begin
        pick = grant_q;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (in_TVALID[(int'(rr_q) + k) % NUM_CH]) begin
                pick = GW'((int'(rr_q) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        hdr_data = sel_data;
        if (STAMP_SRC == 1 && first_q) begin
            hdr_data[HDR_SRC_LSB +: 2*XY_SZ] = HsrcId;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        first_d = first_q;
        case (state_q)
            S_IDLE: begin
                if (|in_TVALID) begin
                    grant_d = pick;
                    state_d = S_LOCK;
                    first_d = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (sel_last) begin
                        state_d = S_IDLE;
                        rr_d    = (grant_q == LAST_CH) ? '0 : grant_q + GW'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_TREADY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            stat_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_data_q <= hdr_data;
                out_keep_q <= sel_keep;
                out_last_q <= sel_last;
            end
            if (out_valid_q && out_TREADY && out_last_q) begin
                stat_q <= stat_q + 32'd1;
            end
        end
    end

    assign out_TVALID = out_valid_q;
    assign out_TDATA  = out_data_q;
    assign out_TKEEP  = out_keep_q;
    assign out_TLAST  = out_last_q;
    assign grant_id   = grant_q;
    assign stat_pkts  = stat_q;

endmodule
